// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types, defaults and helpers for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int c_default_width = 8;
    localparam int c_mag_w         = 64;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_run  = 2'd1;
    localparam state_t c_st_fix  = 2'd2;
    localparam state_t c_st_done = 2'd3;

    // Magnitude of the w-bit two's-complement value held in the low bits of v.
    // The most negative value maps onto its positive unsigned magnitude.
    function automatic logic [c_mag_w-1:0] f_mag(input logic [c_mag_w-1:0] v, input int w);
        logic [c_mag_w-1:0] mask;
        mask = (w >= c_mag_w) ? '1 : ((c_mag_w'(1) << w) - c_mag_w'(1));
        if (v[w-1])
            return (~v + c_mag_w'(1)) & mask;
        else
            return v & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_n.sv
`default_nettype none
// ============================================================================
// Module      : rca_n
// Description : WIDTH-bit ripple-carry adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    endgenerate

    assign o_cout = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/seq_mul_n.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_n
// Description : Sequential shift-and-add multiplier, unsigned or signed per op.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_n
    import mul_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int         c_pw   = 2 * WIDTH;
    localparam [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [c_pw-1:0]    r_product;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [c_pw-1:0]    w_full;
    logic [c_pw-1:0]    w_negated;

    assign w_mag_a   = WIDTH'(f_mag(c_mag_w'(a), WIDTH));
    assign w_mag_b   = WIDTH'(f_mag(c_mag_w'(b), WIDTH));
    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_full    = {r_acc_hi, r_mplier};
    assign w_negated = ~w_full + c_pw'(1);

    rca_n #(
        .WIDTH (WIDTH)
    ) u_step_add (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_st_idle;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (in_valid)        w_next_state = c_st_run;
            c_st_run:  if (r_cnt == c_last) w_next_state = c_st_fix;
            c_st_fix:                       w_next_state = c_st_done;
            c_st_done: if (out_ready)       w_next_state = c_st_idle;
            default:                        w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready = (r_state == c_st_idle);
        busy     = (r_state != c_st_idle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc_hi    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_mcand  <= is_signed ? w_mag_a : a;
                        r_mplier <= is_signed ? w_mag_b : b;
                        r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                    end
                end
                c_st_run: begin
                    // {carry, sum, mplier} shifted right by one
                    r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                c_st_fix: begin
                    r_product   <= r_neg ? w_negated : w_full;
                    r_out_valid <= 1'b1;
                end
                c_st_done: begin
                    if (out_ready)
                        r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign product   = r_product;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul_n
// Description : Directed self-checking bench for seq_mul_n (WIDTH 8 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, busy8;
    logic [15:0] product8;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b1, s4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, busy4;
    logic [7:0]  product4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mul_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(s8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    seq_mul_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .is_signed(s4), .out_valid(out_valid4),
        .out_ready(out_ready4), .product(product4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                       input logic [15:0] exp, input string tag);
        int k;
        a8 = ta; b8 = tb_; s8 = ts; out_ready8 = 1'b1; in_valid8 = 1'b1;
        k = 0;
        while (!in_ready8 && k < 50) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        k = 0;
        while (!out_valid8 && k < 40) begin @(posedge clk); #1; k++; end
        chk({tag, " latency"}, 64'(k), 64'd9);
        chk(tag, 64'(product8), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic ts);
        int k, sa, sb, p;
        logic [7:0] e;
        sa = (ts && ta[3]) ? int'(ta) - 16 : int'(ta);
        sb = (ts && tb_[3]) ? int'(tb_) - 16 : int'(tb_);
        p  = sa * sb;
        e  = p[7:0];
        a4 = ta; b4 = tb_; s4 = ts; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 30) begin @(posedge clk); #1; k++; end
        chk($sformatf("w4 %s %0d*%0d", ts ? "s" : "u", ta, tb_), 64'(product4), 64'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        int k, iv;
        logic seen;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst in_ready",  64'(in_ready8),  64'd1);
        chk("rst out_valid", 64'(out_valid8), 64'd0);
        chk("rst busy",      64'(busy8),      64'd0);
        chk("rst product",   64'(product8),   64'd0);

        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u ff*ff");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s -128*-128");
        op8(8'h80, 8'h01, 1'b1, 16'hFF80, "s -128*1");
        op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s -3*5");
        op8(8'h00, 8'hF9, 1'b1, 16'h0000, "s 0*-7");

        // Backpressure with an ignored in_valid pulse during DONE
        a8 = 8'd5; b8 = 8'd3; s8 = 1'b0; out_ready8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        k = 0;
        while (!out_valid8 && k < 40) begin @(posedge clk); #1; k++; end
        chk("bp first product", 64'(product8), 64'd15);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = (i == 2);
            if (i == 2) begin a8 = 8'd2; b8 = 8'd2; end
            @(posedge clk); #1;
            chk($sformatf("bp hold product c%0d", i), 64'(product8),   64'd15);
            chk($sformatf("bp hold valid c%0d", i),   64'(out_valid8), 64'd1);
        end
        in_valid8 = 1'b0;
        chk("bp in_ready", 64'(in_ready8), 64'd0);
        chk("bp busy",     64'(busy8),     64'd1);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        chk("bp release valid", 64'(out_valid8), 64'd0);
        chk("bp release ready", 64'(in_ready8),  64'd1);
        op8(8'd4, 8'd4, 1'b0, 16'd16, "bp next 4*4");

        // Back-to-back with in_valid held high
        a8 = 8'd7; b8 = 8'd6; s8 = 1'b0; out_ready8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd9; b8 = 8'd9;
        seen = 1'b0; iv = -1;
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk); #1;
            if (out_valid8 && !seen) begin
                chk("b2b first 7*6", 64'(product8), 64'd42);
                seen = 1'b1;
            end
            if (seen && in_ready8) begin iv = j + 1; break; end
        end
        chk("b2b interval", 64'(iv), 64'd11);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        k = 0;
        while (!out_valid8 && k < 40) begin @(posedge clk); #1; k++; end
        chk("b2b second 9*9", 64'(product8), 64'd81);
        chk("b2b second latency", 64'(k), 64'd9);
        @(posedge clk); #1;

        // Reset in the middle of RUN
        a8 = 8'd10; b8 = 8'd10; s8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(out_valid8), 64'd0);
        chk("midrst product",   64'(product8),   64'd0);
        chk("midrst in_ready",  64'(in_ready8),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        op8(8'd3, 8'd4, 1'b0, 16'd12, "after rst 3*4");

        // Exhaustive WIDTH=4, both modes
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op4(4'(x), 4'(y), s[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
